// File: rtl/display_event_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : display_event_scheduler_if
//  Description : Bus bundle for the display event scheduler. Carries the
//                per-requester message post/accept signals, the serialized
//                valid/ready word stream and the status outputs.
//                master : requester/host side (drives requests, out_ready)
//                slave  : scheduler side (drives req_ready, stream, status)
//  Ports       : req_valid, req_fmt, req_argc, req_args, req_ready,
//                out_valid, out_data, out_last, out_ready, err_argc, msg_count
//  Revision    : 1.0  initial release
// ============================================================================
interface display_event_scheduler_if #(
  parameter int NREQ     = 4,
  parameter int MAX_ARGS = 4,
  parameter int DATA_W   = 32,
  parameter int FMT_W    = 16
);
  logic [NREQ-1:0]                 req_valid;
  logic [NREQ*FMT_W-1:0]           req_fmt;
  logic [NREQ*4-1:0]               req_argc;
  logic [NREQ*MAX_ARGS*DATA_W-1:0] req_args;
  logic [NREQ-1:0]                 req_ready;
  logic                            out_valid;
  logic [DATA_W-1:0]               out_data;
  logic                            out_last;
  logic                            out_ready;
  logic                            err_argc;
  logic [15:0]                     msg_count;

  modport master (
    output req_valid, req_fmt, req_argc, req_args, out_ready,
    input  req_ready, out_valid, out_data, out_last, err_argc, msg_count
  );

  modport slave (
    input  req_valid, req_fmt, req_argc, req_args, out_ready,
    output req_ready, out_valid, out_data, out_last, err_argc, msg_count
  );
endinterface
`default_nettype wire

// File: rtl/display_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : display_event_scheduler
//  Description : Round-robin scheduler sharing one $display event channel
//                between NREQ requesters. A granted message is serialized as
//                a header word, an optional timestamp word and its arguments.
//  Ports       : clk  - clock
//                rst  - synchronous reset, active-high
//                bus  - display_event_scheduler_if.slave (requests, stream,
//                       err_argc sticky flag, msg_count)
//  Options     : DISPLAY_SCHED_TIMESTAMP_EN - adds a free-running 32-bit
//                cycle counter, latched at grant and sent as a TS word;
//                header bit 7 flags its presence.
//  Revision    : 1.0  initial release
// ============================================================================
module display_event_scheduler #(
  parameter int NREQ     = 4,
  parameter int MAX_ARGS = 4,
  parameter int DATA_W   = 32,
  parameter int FMT_W    = 16
) (
  input  wire logic               clk,
  input  wire logic               rst,
  display_event_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_ARG  = 2'd2
`ifdef DISPLAY_SCHED_TIMESTAMP_EN
    ,S_TS  = 2'd3
`endif
  } state_t;

  localparam logic [3:0] C_MAX_ARGS = 4'(MAX_ARGS);

  state_t            state_q, state_d;
  logic [2:0]        rr_q, rr_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [FMT_W-1:0]  fmt_q, fmt_d;
  logic [3:0]        argc_q, argc_d;
  logic [3:0]        idx_q, idx_d;
  logic [DATA_W-1:0] args_q [MAX_ARGS];
  logic [DATA_W-1:0] args_d [MAX_ARGS];
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;
`ifdef DISPLAY_SCHED_TIMESTAMP_EN
  logic [31:0]       tsc_q, tsc_d;
  logic [31:0]       ts_q, ts_d;
  logic [DATA_W+31:0] ts_ext;
`endif

  // Round-robin pick: lowest valid index at or above rr_q wins, otherwise
  // the lowest valid index overall (wrap-around).
  logic       any_hi;
  logic [2:0] g_hi, g_lo, g_sel;
  always_comb begin
    any_hi = 1'b0;
    g_hi   = '0;
    g_lo   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        g_lo = 3'(i);
        if (3'(i) >= rr_q) begin
          any_hi = 1'b1;
          g_hi   = 3'(i);
        end
      end
    end
    g_sel = any_hi ? g_hi : g_lo;
  end

  // Payload of the requester being granted.
  logic [FMT_W-1:0]  fmt_sel;
  logic [3:0]        argc_sel;
  logic [DATA_W-1:0] args_sel [MAX_ARGS];
  always_comb begin
    fmt_sel  = '0;
    argc_sel = '0;
    for (int j = 0; j < MAX_ARGS; j++) args_sel[j] = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (g_sel == 3'(i)) begin
        fmt_sel  = bus.req_fmt[i*FMT_W +: FMT_W];
        argc_sel = bus.req_argc[i*4 +: 4];
        for (int j = 0; j < MAX_ARGS; j++)
          args_sel[j] = bus.req_args[(i*MAX_ARGS+j)*DATA_W +: DATA_W];
      end
    end
  end

  // Header fields are packed from bit 0, then fitted to DATA_W.
  logic               ts_flag;
  logic [31:0]        hdr32;
  logic [DATA_W+31:0] hdr_ext;
  logic [DATA_W-1:0]  arg_word;
  always_comb begin
`ifdef DISPLAY_SCHED_TIMESTAMP_EN
    ts_flag = 1'b1;
    ts_ext  = {{DATA_W{1'b0}}, ts_q};
`else
    ts_flag = 1'b0;
`endif
    hdr32    = {16'(fmt_q), 5'd0, gnt_q, ts_flag, 3'd0, argc_q};
    hdr_ext  = {{DATA_W{1'b0}}, hdr32};
    arg_word = '0;
    for (int j = 0; j < MAX_ARGS; j++)
      if (idx_q == 4'(j)) arg_word = args_q[j];
  end

  logic [NREQ-1:0]   req_ready;
  logic              out_valid, out_last;
  logic [DATA_W-1:0] out_data;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    fmt_d     = fmt_q;
    argc_d    = argc_q;
    idx_d     = idx_q;
    args_d    = args_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
`ifdef DISPLAY_SCHED_TIMESTAMP_EN
    tsc_d     = tsc_q + 32'd1;
    ts_d      = ts_q;
`endif
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|bus.req_valid) begin
          req_ready = NREQ'(1) << g_sel;
          gnt_d     = g_sel;
          fmt_d     = fmt_sel;
          argc_d    = (argc_sel > C_MAX_ARGS) ? C_MAX_ARGS : argc_sel;
          args_d    = args_sel;
          idx_d     = '0;
          if (argc_sel > C_MAX_ARGS) err_d = 1'b1;
          rr_d      = (g_sel == 3'(NREQ - 1)) ? 3'd0 : g_sel + 3'd1;
`ifdef DISPLAY_SCHED_TIMESTAMP_EN
          ts_d      = tsc_q;
`endif
          state_d   = S_HDR;
        end
      end

      S_HDR: begin
        out_valid = 1'b1;
        out_data  = hdr_ext[DATA_W-1:0];
`ifdef DISPLAY_SCHED_TIMESTAMP_EN
        if (bus.out_ready) state_d = S_TS;
`else
        out_last  = (argc_q == 4'd0);
        if (bus.out_ready) begin
          if (argc_q == 4'd0) begin
            state_d = S_IDLE;
            cnt_d   = cnt_q + 16'd1;
          end else begin
            state_d = S_ARG;
          end
        end
`endif
      end

`ifdef DISPLAY_SCHED_TIMESTAMP_EN
      S_TS: begin
        out_valid = 1'b1;
        out_data  = ts_ext[DATA_W-1:0];
        out_last  = (argc_q == 4'd0);
        if (bus.out_ready) begin
          if (argc_q == 4'd0) begin
            state_d = S_IDLE;
            cnt_d   = cnt_q + 16'd1;
          end else begin
            state_d = S_ARG;
          end
        end
      end
`endif

      S_ARG: begin
        out_valid = 1'b1;
        out_data  = arg_word;
        out_last  = (idx_q == argc_q - 4'd1);
        if (bus.out_ready) begin
          if (idx_q == argc_q - 4'd1) begin
            state_d = S_IDLE;
            cnt_d   = cnt_q + 16'd1;
          end else begin
            idx_d   = idx_q + 4'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      fmt_q   <= '0;
      argc_q  <= '0;
      idx_q   <= '0;
      for (int j = 0; j < MAX_ARGS; j++) args_q[j] <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef DISPLAY_SCHED_TIMESTAMP_EN
      tsc_q   <= '0;
      ts_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      fmt_q   <= fmt_d;
      argc_q  <= argc_d;
      idx_q   <= idx_d;
      args_q  <= args_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef DISPLAY_SCHED_TIMESTAMP_EN
      tsc_q   <= tsc_d;
      ts_q    <= ts_d;
`endif
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;
  assign bus.err_argc  = err_q;
  assign bus.msg_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_display_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_event_scheduler
//  Description : Self-checking bench for display_event_scheduler. A message
//                level model (pending requests, round-robin pointer, queue of
//                expected stream words) predicts every cycle's outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_display_event_scheduler;
  localparam int NREQ = 4, MAX_ARGS = 4, DATA_W = 32, FMT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_event_scheduler_if #(.NREQ(NREQ), .MAX_ARGS(MAX_ARGS), .DATA_W(DATA_W), .FMT_W(FMT_W)) bus ();

  display_event_scheduler #(.NREQ(NREQ), .MAX_ARGS(MAX_ARGS), .DATA_W(DATA_W), .FMT_W(FMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Requester-side state and reference model.
  bit                pend  [NREQ];
  logic [FMT_W-1:0]  pfmt  [NREQ];
  logic [3:0]        pargc [NREQ];
  logic [DATA_W-1:0] pargs [NREQ][MAX_ARGS];
  int                rr_m   = 0;
  logic [DATA_W-1:0] wq [$];
  int                msgs_m = 0;
  bit                err_m  = 1'b0;
  logic [31:0]       ts_m   = 0;
  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic post(input int i, input logic [FMT_W-1:0] f, input logic [3:0] a);
    pend[i]  = 1'b1;
    pfmt[i]  = f;
    pargc[i] = a;
    for (int j = 0; j < MAX_ARGS; j++) pargs[i][j] = $urandom;
  endtask

  function automatic bit any_pend();
    bit r = 1'b0;
    for (int i = 0; i < NREQ; i++) r |= pend[i];
    return r;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model across the coming edge.
  task automatic cycle(input bit r, input bit rdy);
    int pick;
    int eff;
    logic [31:0] hdr;
    @(posedge clk); #1;
    rst = r;
    bus.out_ready = rdy;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = pend[i] && !r;
      bus.req_fmt[i*FMT_W +: FMT_W] = pfmt[i];
      bus.req_argc[i*4 +: 4] = pargc[i];
      for (int j = 0; j < MAX_ARGS; j++)
        bus.req_args[(i*MAX_ARGS+j)*DATA_W +: DATA_W] = pargs[i][j];
    end
    #1;
    pick = -1;
    if (!r && wq.size() == 0)
      for (int off = 0; off < NREQ; off++)
        if (pick < 0 && pend[(rr_m + off) % NREQ]) pick = (rr_m + off) % NREQ;

    chk("req_ready", 64'(bus.req_ready), (pick >= 0) ? 64'(1) << pick : 64'(0));
    chk("out_valid", 64'(bus.out_valid), 64'(wq.size() != 0));
    if (wq.size() != 0) begin
      chk("out_data", 64'(bus.out_data), 64'(wq[0]));
      chk("out_last", 64'(bus.out_last), 64'(wq.size() == 1));
    end
    chk("msg_count", 64'(bus.msg_count), 64'(msgs_m[15:0]));
    chk("err_argc", 64'(bus.err_argc), 64'(err_m));

    if (r) begin
      wq.delete();
      rr_m = 0; msgs_m = 0; err_m = 1'b0; ts_m = 0;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    end else begin
      if (pick >= 0) begin
        eff = (pargc[pick] > MAX_ARGS) ? MAX_ARGS : int'(pargc[pick]);
        if (pargc[pick] > MAX_ARGS) err_m = 1'b1;
        hdr = {16'(pfmt[pick]), 8'(pick), 8'(eff)};
`ifdef DISPLAY_SCHED_TIMESTAMP_EN
        hdr[7] = 1'b1;
        wq.push_back(hdr);
        wq.push_back(ts_m);
`else
        wq.push_back(hdr);
`endif
        for (int j = 0; j < eff; j++) wq.push_back(pargs[pick][j]);
        pend[pick] = 1'b0;
        rr_m = (pick + 1) % NREQ;
      end else if (wq.size() != 0 && rdy) begin
        void'(wq.pop_front());
        if (wq.size() == 0) msgs_m++;
      end
      ts_m++;
    end
  endtask

  task automatic drain();
    bit done;
    for (int n = 0; n < 300 && (wq.size() != 0 || any_pend()); n++) cycle(1'b0, 1'b1);
    done = (wq.size() == 0) && !any_pend();
    total++;
    assert (done) passed++;
    else $error("FAIL drain_timeout observed=busy expected=idle");
  endtask

  initial begin
    bus.req_valid = '0; bus.req_fmt = '0; bus.req_argc = '0; bus.req_args = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; pfmt[i] = '0; pargc[i] = '0;
      for (int j = 0; j < MAX_ARGS; j++) pargs[i][j] = '0;
    end

    // Reset state
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_last", 64'(bus.out_last), 64'(0));

    // Single message from req0 with two arguments
    post(0, 16'h0005, 4'd2);
    pargs[0][0] = 32'h11; pargs[0][1] = 32'h22;
    drain();
    cycle(1'b0, 1'b1);
    chk("t1_msg_count", 64'(bus.msg_count), 64'(1));

    // All requesters at once, header-only messages
    cycle(1'b1, 1'b1);
    for (int i = 0; i < NREQ; i++) post(i, 16'(16'h0100 + i), 4'd0);
    drain();

    // Back-pressure for three cycles mid-message
    post(1, 16'h0abc, 4'd3);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    drain();

    // Over-long argument count is clamped and flagged
    post(2, 16'h0777, 4'd9);
    drain();
    cycle(1'b0, 1'b1);
    chk("err_sticky", 64'(bus.err_argc), 64'(1));

    // Reset in the middle of a four-argument message
    post(0, 16'h0042, 4'd4);
    for (int n = 0; n < 20 && !(wq.size() == 3); n++) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    chk("rst_mid_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_mid_count", 64'(bus.msg_count), 64'(0));
    post(1, 16'h0011, 4'd1);
    post(0, 16'h0010, 4'd1);
    drain();

    // Grant exactly ten cycles after reset
    cycle(1'b1, 1'b1);
    repeat (10) cycle(1'b0, 1'b1);
    post(3, 16'h0333, 4'd2);
    drain();

    // Randomized traffic with random back-pressure and withdrawals
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0)
          post(i, 16'($urandom), 4'($urandom_range(0, 6)));
        else if (pend[i] && $urandom_range(0, 31) == 0)
          pend[i] = 1'b0;
      end
      cycle(1'b0, $urandom_range(0, 3) != 0);
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
